soc_axi_default_slave: RTL
==========================

// Module: soc_axi_default_slave
// PURPOSE
//  AXI4 default (error) slave sitting directly downstream of the SoC address decoder.
//  Receives every transaction whose address decodes to no slave (decoder dec_error path).
//  Completes those transactions protocol-correctly with DECERR and consumes all write data.
//  Counts decode errors and captures the offending address for debug/safety reporting.
// PARAMETERS
//  ID_W     8    AXI ID width
//  DATA_W   64   AXI data width
//  CNT_W    16   error counter width (saturating)
// PORTS
//  axi_clk        in   1       clock; all logic on rising edge
//  axi_rst_n      in   1       async assert, active-low reset
//  s_awvalid/ready in/out 1    write address handshake
//  s_awid         in   ID_W    write ID
//  s_awaddr       in   32      write address (capture only)
//  s_awlen        in   8       burst length - 1
//  s_wvalid/ready in/out 1     write data handshake
//  s_wlast        in   1       last write beat
//  s_bvalid/ready out/in 1     write response handshake
//  s_bid          out  ID_W    = captured awid
//  s_bresp        out  2       constant 2'b11 (DECERR)
//  s_arvalid/ready in/out 1    read address handshake
//  s_arid         in   ID_W    read ID
//  s_araddr       in   32      read address (capture only)
//  s_arlen        in   8       burst length - 1
//  s_rvalid/ready out/in 1     read data handshake
//  s_rid          out  ID_W    = captured arid
//  s_rdata        out  DATA_W  constant 0
//  s_rresp        out  2       constant 2'b11 (DECERR)
//  s_rlast        out  1       final read beat
//  err_cnt        out  CNT_W   decode-error count, saturating
//  err_addr       out  32      address of most recent accepted error transaction
//  err_wlast_mis  out  1       sticky: wlast beat count != awlen+1
//  err_irq        out  1       1-cycle pulse per accepted AW or AR
// BEHAVIOUR
//  Reset: all ready/valid = 0, bid/rid = 0, rlast = 0, err_cnt = 0, err_addr = 0,
//   err_wlast_mis = 0, err_irq = 0. FSMs in IDLE.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; one outstanding write.
//   W_IDLE: awready = 1 (registered). On AW handshake latch awid, awlen, clear beat cnt -> W_DATA.
//   W_DATA: wready = 1. Each W handshake discards data, beat cnt++. Handshake with wlast -> W_RESP.
//    If beats (incl. last) != awlen+1, set err_wlast_mis. wlast alone terminates the burst.
//   W_RESP: bvalid = 1, bid = latched ID; hold stable until bready -> W_IDLE.
//    awready is low outside W_IDLE; next AW is accepted one cycle after B handshake at earliest.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE; one outstanding read; independent of write FSM.
//   R_IDLE: arready = 1. On AR handshake latch arid, beats_left = arlen -> R_DATA.
//   R_DATA: rvalid = 1, rlast = (beats_left == 0). On R handshake: if rlast -> R_IDLE,
//    else beats_left--. rid/rlast stable while rvalid & !rready.
//   arlen = 255 -> exactly 256 beats; arlen = 0 -> single beat with rlast.
//  Latency: AW/AR accepted in cycle N -> wready / first rvalid visible in cycle N+1.
//   Final W beat in cycle N -> bvalid in cycle N+1.
//  Counter: +1 per AW handshake, +1 per AR handshake; both in same cycle -> +2.
//   Saturates at 2^CNT_W-1 (no wrap; +2 from max-1 gives max).
//  err_addr: updated on AW or AR handshake; simultaneous -> awaddr wins.
//  err_irq: high the cycle after any AW/AR handshake, single cycle even if both occur.
//  Reset mid-burst: FSMs return to IDLE immediately; no response is issued for aborted
//   transactions; counters and sticky flag clear.
// TESTING
//  AW(id=3,len=0)+1 W(wlast) -> bvalid next cycle, bid=3, bresp=2'b11, err_cnt=1.
//  AR(id=5,len=3), rready=1 -> 4 R beats, rdata=0, rresp=2'b11, rlast on 4th only, rid=5.
//  R burst len=1 with rready low 3 cycles mid-burst -> rvalid/rid/rlast held, 2 beats total.
//  AW+AR same cycle, awaddr=0x0A10_0000, araddr=0x0B20_0000 -> err_cnt+=2,
//   err_addr=0x0A10_0000, one err_irq pulse; both channels complete independently.
//  AW len=3 then wlast on beat 2 -> burst ends, B issued, err_wlast_mis=1 until reset.
//  Preload err_cnt=0xFFFE, issue AW+AR same cycle -> err_cnt=0xFFFF, stays at 0xFFFF after.

Source files
------------

// File: rtl/soc_axi_default_slave.sv
// AXI4 default (decode-error) slave: completes unmapped transactions with DECERR,
// drains write data, and records a saturating error count plus the offending address.
module soc_axi_default_slave #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              i_axi_clk,
    input  logic              i_axi_rst_n,
    input  logic              i_s_awvalid,
    output logic              o_s_awready,
    input  logic [ID_W-1:0]   i_s_awid,
    input  logic [31:0]       i_s_awaddr,
    input  logic [7:0]        i_s_awlen,
    input  logic              i_s_wvalid,
    output logic              o_s_wready,
    input  logic              i_s_wlast,
    output logic              o_s_bvalid,
    input  logic              i_s_bready,
    output logic [ID_W-1:0]   o_s_bid,
    output logic [1:0]        o_s_bresp,
    input  logic              i_s_arvalid,
    output logic              o_s_arready,
    input  logic [ID_W-1:0]   i_s_arid,
    input  logic [31:0]       i_s_araddr,
    input  logic [7:0]        i_s_arlen,
    output logic              o_s_rvalid,
    input  logic              i_s_rready,
    output logic [ID_W-1:0]   o_s_rid,
    output logic [DATA_W-1:0] o_s_rdata,
    output logic [1:0]        o_s_rresp,
    output logic              o_s_rlast,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic [31:0]       o_err_addr,
    output logic              o_err_wlast_mis,
    output logic              o_err_irq
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t          r_wstate, w_wstate_nxt;
    rstate_t          r_rstate, w_rstate_nxt;
    logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast;
    logic [ID_W-1:0]  r_awid, r_arid;
    logic [7:0]       r_awlen;
    logic [8:0]       r_wbeats, w_wbeats_nxt;
    logic [7:0]       r_beats_left, w_beats_nxt;
    logic             w_mis_set;
    logic [CNT_W-1:0] r_err_cnt;
    logic [31:0]      r_err_addr;
    logic             r_err_mis, r_err_irq;
    logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_aw_hs = i_s_awvalid & r_awready;
    assign w_w_hs  = i_s_wvalid  & r_wready;
    assign w_b_hs  = r_bvalid    & i_s_bready;
    assign w_ar_hs = i_s_arvalid & r_arready;
    assign w_r_hs  = r_rvalid    & i_s_rready;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wbeats_nxt = r_wbeats;
        w_mis_set    = 1'b0;
        case (r_wstate)
            W_IDLE: if (w_aw_hs) begin
                w_wstate_nxt = W_DATA;
                w_wbeats_nxt = '0;
            end
            W_DATA: if (w_w_hs) begin
                w_wbeats_nxt = r_wbeats + 9'd1;
                // wlast ends the burst regardless of the announced length
                if (i_s_wlast) begin
                    w_wstate_nxt = W_RESP;
                    w_mis_set    = (w_wbeats_nxt != ({1'b0, r_awlen} + 9'd1));
                end
            end
            W_RESP: if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_beats_nxt  = r_beats_left;
        case (r_rstate)
            R_IDLE: if (w_ar_hs) begin
                w_rstate_nxt = R_DATA;
                w_beats_nxt  = i_s_arlen;
            end
            R_DATA: if (w_r_hs) begin
                if (r_rlast) w_rstate_nxt = R_IDLE;
                else         w_beats_nxt  = r_beats_left - 8'd1;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are clean flops.
    always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
        if (!i_axi_rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_wbeats  <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            r_wbeats  <= w_wbeats_nxt;
            if (w_aw_hs) begin
                r_awid  <= i_s_awid;
                r_awlen <= i_s_awlen;
            end
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
        if (!i_axi_rst_n) begin
            r_rstate     <= R_IDLE;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_arid       <= '0;
            r_beats_left <= '0;
        end else begin
            r_rstate     <= w_rstate_nxt;
            r_arready    <= (w_rstate_nxt == R_IDLE);
            r_rvalid     <= (w_rstate_nxt == R_DATA);
            r_rlast      <= (w_rstate_nxt == R_DATA) && (w_beats_nxt == 8'd0);
            r_beats_left <= w_beats_nxt;
            if (w_ar_hs) r_arid <= i_s_arid;
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
        if (!i_axi_rst_n) begin
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_err_mis  <= 1'b0;
            r_err_irq  <= 1'b0;
        end else begin
            r_err_cnt <= sat_add(r_err_cnt, {1'b0, w_aw_hs} + {1'b0, w_ar_hs});
            r_err_irq <= w_aw_hs | w_ar_hs;
            r_err_mis <= r_err_mis | w_mis_set;
            if (w_aw_hs)      r_err_addr <= i_s_awaddr;
            else if (w_ar_hs) r_err_addr <= i_s_araddr;
        end
    end

    assign o_s_awready     = r_awready;
    assign o_s_wready      = r_wready;
    assign o_s_bvalid      = r_bvalid;
    assign o_s_bid         = r_awid;
    assign o_s_bresp       = 2'b11;
    assign o_s_arready     = r_arready;
    assign o_s_rvalid      = r_rvalid;
    assign o_s_rid         = r_arid;
    assign o_s_rdata       = '0;
    assign o_s_rresp       = 2'b11;
    assign o_s_rlast       = r_rlast;
    assign o_err_cnt       = r_err_cnt;
    assign o_err_addr      = r_err_addr;
    assign o_err_wlast_mis = r_err_mis;
    assign o_err_irq       = r_err_irq;

endmodule
